fetch_unit_rv32i: RTL and testbench



---
 rtl/rv32i_pkg.sv | 18 +
 rtl/fetch_unit_rv32i_if.sv | 26 ++
 rtl/fetch_fifo_rv32i.sv | 50 +++++
 rtl/fetch_unit_rv32i.sv | 131 +++++++++++++
 tb/tb_fetch_unit_rv32i.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: the canonical NOP encoding, the fetch FSM states
// and the {pc, instr} entry held in the prefetch buffer.
package rv32i_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_rv32i_if.sv
// Fetch-stage bundle: instruction-memory read port, execute redirect and the
// valid/ready handoff to decode. master = fetch unit, slave = its environment.
interface fetch_unit_rv32i_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo_rv32i.sv
// Prefetch buffer of {pc, instr} entries. Flush empties the buffer and wins
// over a push in the same cycle. Callers never push when full or pop when empty.
module fetch_fifo_rv32i
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             data_i,
    input  logic                     pop_i,
    output fetch_entry_t             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_rv32i.sv
// RV32I instruction fetch: one outstanding word read, a prefetch buffer toward
// decode and redirect flushing. Define FETCH_BYPASS_EN to forward an ack
// straight to decode when the buffer is empty and decode is ready.
module fetch_unit_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                clock,
    input logic                reset,
    fetch_unit_rv32i_if.master fetch_if
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e   state_q;
    logic           req_q;
    logic [31:0]    req_addr_q;
    logic [31:0]    fetch_pc_q;

    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  occ_after_pop;
    logic [31:0]    redirect_tgt;
    logic           fifo_empty;
    logic           ack_live;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           space_idle;
    logic           space_req;

    assign redirect_tgt  = fetch_if.redirect_pc & ~32'h0000_0003;
    assign fifo_empty    = (fifo_count == '0);
    assign ack_live      = (state_q == REQ) && fetch_if.imem_ack && !fetch_if.redirect;
`ifdef FETCH_BYPASS_EN
    assign bypass        = ack_live && fifo_empty && fetch_if.out_ready;
`else
    assign bypass        = 1'b0;
`endif
    assign push          = ack_live && !bypass;
    assign pop           = !fifo_empty && fetch_if.out_ready;
    assign occ_after_pop = fifo_count - CW'(pop);
    assign space_idle    = occ_after_pop < CW'(DEPTH);
    assign space_req     = (occ_after_pop + CW'(push)) < CW'(DEPTH);
    assign push_entry    = '{pc: req_addr_q, instr: fetch_if.imem_rdata};

    fetch_fifo_rv32i #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (fetch_if.redirect),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count)
    );

    // Request FSM: a request, once issued, stays up until its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_addr_q <= 32'h0;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_if.redirect) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= redirect_tgt;
                        fetch_pc_q <= redirect_tgt + 32'd4;
                    end else if (space_idle) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                end
                REQ: begin
                    if (fetch_if.redirect) begin
                        fetch_pc_q <= redirect_tgt;
                        if (fetch_if.imem_ack) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (fetch_if.imem_ack) begin
                        if (space_req) begin
                            req_addr_q <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (fetch_if.redirect) fetch_pc_q <= redirect_tgt;
                    if (fetch_if.imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_if.imem_req  = req_q;
    assign fetch_if.imem_addr = req_addr_q;

    always_comb begin
        fetch_if.out_valid = !fifo_empty;
        fetch_if.out_instr = fifo_empty ? RV32I_NOP : head.instr;
        fetch_if.out_pc    = fifo_empty ? 32'h0 : head.pc;
        if (bypass) begin
            fetch_if.out_valid = 1'b1;
            fetch_if.out_instr = fetch_if.imem_rdata;
            fetch_if.out_pc    = req_addr_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Bench for fetch_unit_rv32i: directed cycle checks plus a randomized run
// scored against the expected program-order PC stream.
module tb_fetch_unit_rv32i;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;
    int deliv = 0;

    int unsigned wait_cnt  = 0;
    int unsigned cur_lat   = 0;
    int unsigned mem_lat   = 0;
    bit          mem_rand  = 1'b0;
    bit          ack_force = 1'b0;

    logic [31:0] exp_pc    = 32'h0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clock = ~clock;

    fetch_unit_rv32i_if bus ();
    fetch_unit_rv32i_if bus2 ();

    fetch_unit_rv32i #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .fetch_if (bus)
    );

    fetch_unit_rv32i #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_wrap (
        .clock    (clock),
        .reset    (reset),
        .fetch_if (bus2)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack after cur_lat waiting cycles (0 = same cycle as request).
    always @(posedge clock) begin
        if (bus.imem_req && !bus.imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            cur_lat  <= mem_rand ? $urandom_range(0, 3) : mem_lat;
        end
    end

    assign bus.imem_ack    = ack_force || (bus.imem_req && (wait_cnt >= cur_lat));
    assign bus.imem_rdata  = instr_of(bus.imem_addr);
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = instr_of(bus2.imem_addr);
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 32'h0;
    assign bus2.out_ready   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream model: decode sees consecutive PCs from the last reset/redirect.
    task automatic score();
        if (reset) begin
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
            exp_pc    = 32'h0;
            prev_wait = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_pc", bus.out_pc, exp_pc);
                chk("stream_instr", bus.out_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliv++;
            end
            if (!bus.out_valid) chk("idle_nop", bus.out_instr, 32'h0000_0013);
            if (bus.imem_req) chk("addr_align", {30'h0, bus.imem_addr[1:0]}, 32'h0);
            if (prev_wait && bus.imem_req) chk("addr_hold", bus.imem_addr, prev_addr);
            prev_wait = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            if (bus.redirect) exp_pc = bus.redirect_pc & ~32'h3;
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
        score();
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        smp();
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_instr", bus.out_instr, 32'h0000_0013);
        chk("rst_pc", bus.out_pc, 32'h0);

        // Zero-wait streaming from RESET_PC
        nxt(); reset = 1'b0; smp();
        chk("r0_req", 32'(bus.imem_req), 32'h0);
        nxt(); smp();
        chk("r1_req", 32'(bus.imem_req), 32'h1);
        chk("r1_addr", bus.imem_addr, 32'h0);
        chk("r1_valid", 32'(bus.out_valid), 32'h0);
        chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        nxt(); smp();
        chk("r2_pc", bus.out_pc, 32'h0);
        chk("r2_addr", bus.imem_addr, 32'h4);
        chk("wrap_pc0", bus2.out_pc, 32'hFFFF_FFF8);
        nxt(); smp();
        chk("r3_pc", bus.out_pc, 32'h4);
        chk("r3_addr", bus.imem_addr, 32'h8);
        chk("wrap_pc1", bus2.out_pc, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("r4_pc", bus.out_pc, 32'h8);
        chk("wrap_pc2", bus2.out_pc, 32'h0);
        chk("wrap_valid2", 32'(bus2.out_valid), 32'h1);

        // Decode stall: buffer fills to DEPTH, requests stop
        nxt(); bus.out_ready = 1'b0; smp();
        repeat (4) begin nxt(); smp(); end
        chk("stall_req", 32'(bus.imem_req), 32'h0);
        chk("stall_valid", 32'(bus.out_valid), 32'h1);
        chk("stall_pc", bus.out_pc, 32'hC);
        nxt(); bus.out_ready = 1'b1; smp();
        chk("rel_pc", bus.out_pc, 32'hC);
        chk("rel_req", 32'(bus.imem_req), 32'h0);
        nxt(); smp();
        chk("res_req", 32'(bus.imem_req), 32'h1);
        chk("res_addr", bus.imem_addr, 32'h14);
        chk("res_pc", bus.out_pc, 32'h10);
        nxt(); smp();
        chk("res_pc2", bus.out_pc, 32'h14);

        // Slow memory, redirect while the first request is pending
        nxt(); mem_lat = 2; reset = 1'b1; smp();
        chk("rst2_req", 32'(bus.imem_req), 32'h0);
        nxt(); smp();
        nxt(); reset = 1'b0; smp();
        nxt(); bus.redirect = 1'b1; bus.redirect_pc = 32'h100; smp();
        chk("d1_addr", bus.imem_addr, 32'h0);
        chk("d1_ack", 32'(bus.imem_ack), 32'h0);
        nxt(); bus.redirect = 1'b0; smp();
        chk("d2_req", 32'(bus.imem_req), 32'h1);
        chk("d2_addr", bus.imem_addr, 32'h0);
        nxt(); smp();
        chk("d3_ack", 32'(bus.imem_ack), 32'h1);
        nxt(); smp();
        chk("d4_req", 32'(bus.imem_req), 32'h0);
        chk("d4_valid", 32'(bus.out_valid), 32'h0);
        nxt(); smp();
        chk("d5_addr", bus.imem_addr, 32'h100);
        nxt(); smp();
        nxt(); smp();
        nxt(); mem_lat = 0; bus.out_ready = 1'b0; smp();
        chk("d8_valid", 32'(bus.out_valid), 32'h1);
        chk("d8_pc", bus.out_pc, 32'h100);

        // Redirect to a misaligned target with the buffer full
        repeat (12) begin nxt(); smp(); end
        chk("full_req", 32'(bus.imem_req), 32'h0);
        nxt(); bus.redirect = 1'b1; bus.redirect_pc = 32'h203; bus.out_ready = 1'b1; smp();
        nxt(); bus.redirect = 1'b0; smp();
        chk("f1_req", 32'(bus.imem_req), 32'h1);
        chk("f1_addr", bus.imem_addr, 32'h200);
        chk("f1_valid", 32'(bus.out_valid), 32'h0);
        nxt(); smp();
        chk("f2_pc", bus.out_pc, 32'h200);

        // Reset while a request is outstanding; a late ack must be ignored
        nxt(); mem_lat = 3; smp();
        for (int i = 0; i < 20 && !(bus.imem_req && !bus.imem_ack); i++) begin
            nxt(); smp();
        end
        chk("pend_seen", 32'(bus.imem_req && !bus.imem_ack), 32'h1);
        reset = 1'b1; mem_lat = 0;
        #1;
        chk("prst_req", 32'(bus.imem_req), 32'h0);
        chk("prst_valid", 32'(bus.out_valid), 32'h0);
        chk("prst_instr", bus.out_instr, 32'h0000_0013);
        nxt(); smp();
        nxt(); reset = 1'b0; ack_force = 1'b1; smp();
        chk("late_req", 32'(bus.imem_req), 32'h0);
        nxt(); ack_force = 1'b0; smp();
        chk("late_valid", 32'(bus.out_valid), 32'h0);
        chk("rs_addr", bus.imem_addr, 32'h0);
        chk("rs_req", 32'(bus.imem_req), 32'h1);
        nxt(); smp();
        chk("rs_pc", bus.out_pc, 32'h0);
        chk("rs_pcvalid", 32'(bus.out_valid), 32'h1);

        // Randomized latency, stalls and redirects (including near-wrap targets)
        mem_rand = 1'b1;
        deliv    = 0;
        for (int i = 0; i < 800; i++) begin
            nxt();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = ($urandom_range(0, 3) == 0) ?
                                  32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
            end else begin
                bus.redirect = 1'b0;
            end
            smp();
        end
        chk("progress", 32'(deliv >= 60), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
